// File: rtl/adc_scanner_pkg.sv
// adc_scanner shared types: FSM states, register
// addresses and CTRL/STATUS bit positions.
package adc_scanner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    CAPTURE
  } state_e;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h1;

  localparam int C_EN      = 0;
  localparam int C_ONESHOT = 1;
  localparam int C_MASK_LO = 8;

  localparam int S_RUN      = 0;
  localparam int S_TOERR    = 1;
  localparam int S_DONE     = 2;
  localparam int S_CH_LO    = 4;
  localparam int S_SWEEP_LO = 16;

endpackage

// File: rtl/adc_next_channel.sv
// adc_next_channel: lowest set mask bit strictly above
// cur, or the lowest set bit with wrapped=1 if none.
module adc_next_channel #(
  parameter int NCH = 8
) (
  input  logic [NCH-1:0] mask,
  input  logic [2:0]     cur,
  output logic [2:0]     nxt,
  output logic [2:0]     first,
  output logic           wrapped,
  output logic           any
);

  logic [2:0] above;
  logic       found;

  // Descending scan so the last hit is the lowest bit
  always_comb begin
    above = '0;
    found = 1'b0;
    first = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = 3'(i);
        if (i > int'(cur)) begin
          above = 3'(i);
          found = 1'b1;
        end
      end
    end
  end

  assign any     = |mask;
  assign wrapped = !found;
  assign nxt     = found ? above : first;

endmodule

// File: rtl/adc_scanner.sv
// adc_scanner: round-robin ADC channel sequencer.
// Define ADC_FILTER_EN for per-channel IIR results.
module adc_scanner
  import adc_scanner_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [3:0]  ADDR,
  input  logic [31:0] DATA_IN,
  input  logic        WR,
  output logic [31:0] DATA_OUT,
  output logic [31:0] ADC_DATA_IN,
  output logic        ADC_WR,
  input  logic [31:0] ADC_DATA_OUT,
  output logic        IRQ
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // WR cycle plus waited cycles reach TIMEOUT
  // exactly when TOERR becomes visible
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT - 2);

  state_e state_q, state_n;

  logic           en_q;
  logic           oneshot_q;
  logic [7:0]     mask_q;
  logic           toerr_q;
  logic           done_q;
  logic [2:0]     chan_q;
  logic [15:0]    sweep_q;
  logic [TW-1:0]  cnt_q;
  logic [NCH-1:0] valid_q;
  logic [11:0]    res_q [NCH];

  logic       busy;
  logic [2:0] nxt;
  logic [2:0] first;
  logic       wrapped;
  logic       any;
  logic       start;
  logic       cap;
  logic       to_hit;
  logic       stop;
  logic       wr_ctrl;
  logic       wr_stat;
  logic [11:0] x;
  logic [11:0] cap_val;
  logic        unused_bits;

  assign busy    = ADC_DATA_OUT[31];
  assign x       = ADC_DATA_OUT[11:0];
  assign wr_ctrl = WR && (ADDR == A_CTRL);
  assign wr_stat = WR && (ADDR == A_STATUS);
  assign IRQ     = done_q;

  assign unused_bits = ^{ADC_DATA_OUT[30:12],
                         DATA_IN[31:16],
                         DATA_IN[7:3]};

  adc_next_channel #(
    .NCH(NCH)
  ) u_next (
    .mask    (mask_q[NCH-1:0]),
    .cur     (chan_q),
    .nxt     (nxt),
    .first   (first),
    .wrapped (wrapped),
    .any     (any)
  );

`ifdef ADC_FILTER_EN
  logic [11:0]        y;
  logic               y_valid;
  logic signed [12:0] diff;

  // Previous result of the channel being captured
  always_comb begin
    y       = '0;
    y_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (chan_q == 3'(i)) begin
        y       = res_q[i];
        y_valid = valid_q[i];
      end
    end
  end

  assign diff    = $signed({1'b0, x}) -
                   $signed({1'b0, y});
  assign cap_val = y_valid ?
                   y + 12'(diff >>> 2) : x;
`else
  assign cap_val = x;
`endif

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_n;
  end

  // Next state and ADC request outputs
  always_comb begin
    state_n     = state_q;
    ADC_WR      = 1'b0;
    ADC_DATA_IN = '0;
    start       = 1'b0;
    cap         = 1'b0;
    to_hit      = 1'b0;
    stop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_q && any && !busy) begin
          start   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        ADC_WR      = 1'b1;
        ADC_DATA_IN = {29'b0, chan_q};
        state_n     = WAIT_START;
      end
      WAIT_START: begin
        if (busy) begin
          state_n = WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          to_hit  = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!busy) state_n = CAPTURE;
      end
      CAPTURE: begin
        cap = 1'b1;
        if (!any) begin
          state_n = IDLE;
        end else if (wrapped && oneshot_q) begin
          stop    = 1'b1;
          state_n = IDLE;
        end else if (!en_q) begin
          state_n = IDLE;
        end else begin
          state_n = ISSUE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registers; hardware sets override CPU writes
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      mask_q    <= '0;
      toerr_q   <= 1'b0;
      done_q    <= 1'b0;
      chan_q    <= '0;
      sweep_q   <= '0;
      cnt_q     <= '0;
      valid_q   <= '0;
      for (int i = 0; i < NCH; i++)
        res_q[i] <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q      <= DATA_IN[C_EN];
        oneshot_q <= DATA_IN[C_ONESHOT];
        mask_q    <= DATA_IN[C_MASK_LO +: 8];
        valid_q   <= '0;
      end
      if (wr_stat) begin
        if (DATA_IN[S_TOERR]) toerr_q <= 1'b0;
        if (DATA_IN[S_DONE])  done_q  <= 1'b0;
      end
      if (start) chan_q <= first;
      if (ADC_WR)
        cnt_q <= '0;
      else if (state_q == WAIT_START)
        cnt_q <= cnt_q + TW'(1);
      if (to_hit) begin
        toerr_q <= 1'b1;
        en_q    <= 1'b0;
      end
      if (cap) begin
        for (int i = 0; i < NCH; i++) begin
          if (chan_q == 3'(i)) begin
            res_q[i]   <= cap_val;
            valid_q[i] <= 1'b1;
          end
        end
        if (any) begin
          chan_q <= nxt;
          if (wrapped) begin
            sweep_q <= sweep_q + 16'd1;
            done_q  <= 1'b1;
          end
        end
        if (stop) en_q <= 1'b0;
      end
    end
  end

  // CPU read mux
  always_comb begin
    DATA_OUT = '0;
    unique case (1'b1)
      (ADDR == A_CTRL): begin
        DATA_OUT[C_EN]           = en_q;
        DATA_OUT[C_ONESHOT]      = oneshot_q;
        DATA_OUT[C_MASK_LO +: 8] = mask_q;
      end
      (ADDR == A_STATUS): begin
        DATA_OUT[S_RUN]            = state_q != IDLE;
        DATA_OUT[S_TOERR]          = toerr_q;
        DATA_OUT[S_DONE]           = done_q;
        DATA_OUT[S_CH_LO +: 3]     = chan_q;
        DATA_OUT[S_SWEEP_LO +: 16] = sweep_q;
      end
      ADDR[3]: begin
        for (int i = 0; i < NCH; i++) begin
          if (ADDR[2:0] == 3'(i))
            DATA_OUT = {valid_q[i], 19'b0,
                        res_q[i]};
        end
      end
      default: DATA_OUT = '0;
    endcase
  end

endmodule

// File: tb/tb_adc_scanner.sv
// tb_adc_scanner: directed tests with an ADC model
// and a scoreboard of expected ADC requests.
module tb_adc_scanner;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  ADDR;
  logic [31:0] DATA_IN;
  logic        WR;
  logic [31:0] DATA_OUT;
  logic [31:0] ADC_DATA_IN;
  logic        ADC_WR;
  logic [31:0] ADC_DATA_OUT;
  logic        IRQ;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_wr_cyc = 0;

  logic [2:0]  exp_q[$];
  logic [11:0] samp_q[$];
  logic [11:0] res_tab [8];
  int          mcnt = 0;
  logic [11:0] mres = '0;
  bit          silent = 1'b0;
  bit          force_busy = 1'b0;

  adc_scanner dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .ADDR         (ADDR),
    .DATA_IN      (DATA_IN),
    .WR           (WR),
    .DATA_OUT     (DATA_OUT),
    .ADC_DATA_IN  (ADC_DATA_IN),
    .ADC_WR       (ADC_WR),
    .ADC_DATA_OUT (ADC_DATA_OUT),
    .IRQ          (IRQ)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // ADC model: busy for 10 cycles after each request
  always @(posedge CLK) begin
    if (ADC_WR && !silent) begin
      mcnt <= 10;
      if (samp_q.size() > 0)
        mres <= samp_q.pop_front();
      else
        mres <= res_tab[ADC_DATA_IN[2:0]];
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign ADC_DATA_OUT = {force_busy || (mcnt != 0),
                         19'b0, mres};

  // Monitor: every ADC request must match the queue
  always @(negedge CLK) begin
    logic [2:0] e;
    if (RESET_N === 1'b1 && ADC_WR === 1'b1) begin
      n_cmp++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL adc_wr_unexpected: got %h want none",
                 ADC_DATA_IN);
      end else begin
        e = exp_q.pop_front();
        if (ADC_DATA_IN !== {29'b0, e}) begin
          n_err++;
          $display("FAIL adc_wr_chan: got %h want %h",
                   ADC_DATA_IN, {29'b0, e});
        end
      end
    end
  end

  task automatic cpu_wr(input logic [3:0] a,
                        input logic [31:0] d);
    @(negedge CLK);
    ADDR = a; DATA_IN = d; WR = 1'b1;
    @(negedge CLK);
    WR = 1'b0; DATA_IN = '0;
  endtask

  task automatic chk_reg(input logic [3:0] a,
                         input logic [31:0] exp,
                         input string nm);
    @(negedge CLK);
    ADDR = a;
    #1;
    n_cmp++;
    if (DATA_OUT !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               nm, DATA_OUT, exp);
    end
  endtask

  task automatic chk_bit(input logic act,
                         input logic exp,
                         input string nm);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b",
               nm, act, exp);
    end
  endtask

  // Poll a STATUS field until it equals val
  task automatic wait_stat(input int lo, input int w,
                           input int val, input int budget,
                           input string nm,
                           output int at_cyc);
    int got;
    at_cyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      ADDR = 4'h1;
      #1;
      got = int'((DATA_OUT >> lo) &
                 ((32'd1 << w) - 32'd1));
      if (got == val) begin
        at_cyc = cyc;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout want %0d", nm, val);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0; WR = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    int t;
    RESET_N = 1'b0; ADDR = '0; DATA_IN = '0; WR = 1'b0;
    for (int i = 0; i < 8; i++) res_tab[i] = 12'h0;
    do_reset();

    // Reset state
    chk_reg(4'h0, 32'h0, "rst_ctrl");
    chk_bit(IRQ, 1'b0, "rst_irq");
    chk_bit(ADC_WR, 1'b0, "rst_adc_wr");
    chk_bit(ADC_DATA_IN == 32'h0, 1'b1, "rst_adc_din");
    chk_reg(4'h1, 32'h0, "rst_status");
    chk_reg(4'h8, 32'h0, "rst_res0");
    chk_reg(4'h5, 32'h0, "unmapped_5");

    // Round robin over ch0, ch2; EN dropped mid-conversion
    res_tab[0] = 12'h123;
    res_tab[2] = 12'hABC;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd0);
    cpu_wr(4'h0, 32'h0000_0501);
    wait_stat(2, 1, 1, 200, "wait_done1", t);
    chk_reg(4'h8, 32'h8000_0123, "rr_res0");
    chk_reg(4'hA, 32'h8000_0ABC, "rr_res2");
    cpu_wr(4'h0, 32'h0000_0500);
    wait_stat(0, 1, 0, 200, "wait_idle1", t);
    chk_reg(4'h8, 32'h8000_0123, "en_clr_res0");
    chk_reg(4'hA, 32'h0000_0ABC, "ctrl_clr_valid2");
    chk_reg(4'h1, 32'h0001_0024, "rr_status");
    chk_bit(IRQ, 1'b1, "rr_irq");
    repeat (20) @(negedge CLK);
    cpu_wr(4'h1, 32'h0000_0004);
    chk_reg(4'h1, 32'h0001_0020, "done_w1c");
    chk_bit(IRQ, 1'b0, "irq_cleared");

    // Oneshot on ch7
    do_reset();
    res_tab[7] = 12'h7F7;
    exp_q.push_back(3'd7);
    cpu_wr(4'h0, 32'h0000_8003);
    repeat (3) @(negedge CLK);
    wait_stat(0, 1, 0, 200, "wait_idle2", t);
    chk_reg(4'h0, 32'h0000_8002, "os_en_clr");
    chk_reg(4'h1, 32'h0001_0074, "os_status");
    chk_reg(4'hF, 32'h8000_07F7, "os_res7");

    // Converter never answers: timeout
    do_reset();
    silent = 1'b1;
    exp_q.push_back(3'd3);
    cpu_wr(4'h0, 32'h0000_0801);
    wait_stat(1, 1, 1, 400, "wait_toerr", t);
    n_cmp++;
    if (t - last_wr_cyc != 255) begin
      n_err++;
      $display("FAIL toerr_delay: got %0d want 255",
               t - last_wr_cyc);
    end
    chk_reg(4'h0, 32'h0000_0800, "to_en_clr");
    chk_reg(4'h1, 32'h0000_0032, "to_status");
    cpu_wr(4'h1, 32'h0000_0002);
    chk_reg(4'h1, 32'h0000_0030, "toerr_w1c");
    silent = 1'b0;

    // Converter busy across reset release
    force_busy = 1'b1;
    do_reset();
    res_tab[1] = 12'h555;
    cpu_wr(4'h0, 32'h0000_0203);
    repeat (20) @(negedge CLK);
    chk_reg(4'h1, 32'h0000_0000, "busy_hold_idle");
    exp_q.push_back(3'd1);
    force_busy = 1'b0;
    wait_stat(2, 1, 1, 200, "wait_done4", t);
    wait_stat(0, 1, 0, 200, "wait_idle4", t);
    chk_reg(4'h1, 32'h0001_0014, "busy_status");
    chk_reg(4'h9, 32'h8000_0555, "busy_res1");
    chk_reg(4'h0, 32'h0000_0202, "busy_ctrl");

`ifdef ADC_FILTER_EN
    // IIR step response on ch1
    begin
      logic [31:0] fexp [5];
      fexp[0] = 32'h8000_0000;
      fexp[1] = 32'h8000_0100;
      fexp[2] = 32'h8000_01C0;
      fexp[3] = 32'h8000_0250;
      fexp[4] = 32'h8000_02BC;
      do_reset();
      samp_q.push_back(12'h000);
      for (int i = 0; i < 4; i++)
        samp_q.push_back(12'h400);
      for (int i = 0; i < 6; i++)
        exp_q.push_back(3'd1);
      cpu_wr(4'h0, 32'h0000_0201);
      for (int k = 0; k < 5; k++) begin
        wait_stat(16, 16, k + 1, 200, "wait_filt", t);
        chk_reg(4'h9, fexp[k], "filt_res1");
      end
      cpu_wr(4'h0, 32'h0000_0200);
      wait_stat(0, 1, 0, 200, "wait_idle5", t);
    end
`endif

    repeat (30) @(negedge CLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wr_queue_empty: got %0d want 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
